// File: rtl/prog_loader_pkg.sv
// Shared types for the boot loader: FSM state encoding, error codes and the default frame header.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  typedef logic [1:0] err_t;

  localparam err_t ERR_NONE = 2'b00;
  localparam err_t ERR_CSUM = 2'b01;
  localparam err_t ERR_TMO  = 2'b10;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: a down-counter reloaded on every accepted byte; expires at terminal count zero.
module loader_timeout #(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Holding at LOAD while disabled means every frame starts with a full window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= LOAD;
    end else if (clear || !enable) begin
      count <= LOAD;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = enable && !clear && (count == '0);

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream boot loader: writes the image to program memory and holds the micro in reset until done.
// Optional checksum byte and CHK state are enabled by defining PROG_LOADER_CHECKSUM_EN.
//
// state  | meaning
// S_IDLE | waiting for the sync byte, other bytes dropped
// S_LEN  | next byte is the word count (0 = full 256)
// S_DATA | each byte is written to program memory
// S_CHK  | next byte is the checksum (checksum build only)
// S_RUN  | image accepted, micro released
// S_ERR  | frame aborted, micro held, err_code valid
module program_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned         ADDR_W    = 8,
  parameter int unsigned         DATA_W    = 8,
  parameter logic [DATA_W-1:0]   SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int unsigned         TIMEOUT   = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] pm_wr_addr,
  output logic [DATA_W-1:0] pm_wr_data,
  output logic              pm_wren,
  output logic              micro_reset,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code
);

  state_t            state, state_next;
  err_t              err_next;
  logic              take;
  logic              is_sync;
  logic              wr_next;
  logic              tmo_en;
  logic              tmo_expired;
  logic [DATA_W-1:0] rem;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
`endif

  assign rx_ready = 1'b1;
  assign take     = rx_valid & rx_ready;
  assign is_sync  = take && (rx_data == SYNC_BYTE);
  assign tmo_en   = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);

  loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (take),
    .enable  (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    err_next   = err_code;
    wr_next    = 1'b0;
    case (state)
      S_IDLE: if (is_sync) state_next = S_LEN;
      S_LEN:  if (take) state_next = S_DATA;
      S_DATA: begin
        if (take) begin
          wr_next = 1'b1;
          if (rem == DATA_W'(1)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_next = S_CHK;
`else
            state_next = S_RUN;
`endif
          end
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (take) begin
          if (rx_data == sum) begin
            state_next = S_RUN;
          end else begin
            state_next = S_ERR;
            err_next   = ERR_CSUM;
          end
        end
      end
`endif
      S_RUN:  if (is_sync) state_next = S_LEN;
      S_ERR:  if (is_sync) state_next = S_LEN;
      default: state_next = S_IDLE;
    endcase
    // expired is only raised in LEN/DATA/CHK and never alongside an accepted byte
    if (tmo_expired) begin
      state_next = S_ERR;
      err_next   = ERR_TMO;
    end
    if (state_next != S_ERR) err_next = ERR_NONE;
  end

  // rem counts down modulo 2^DATA_W, so a LEN of 0 naturally yields 256 words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem        <= '0;
      pm_wr_addr <= '0;
      pm_wr_data <= '0;
      pm_wren    <= 1'b0;
    end else begin
      pm_wren <= wr_next;
      if (wr_next) pm_wr_data <= rx_data;
      if ((state == S_LEN) && take) begin
        rem        <= rx_data;
        pm_wr_addr <= '0;
      end else begin
        if (pm_wren) pm_wr_addr <= pm_wr_addr + 1'b1;
        if (wr_next) rem <= rem - 1'b1;
      end
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum <= '0;
    end else if ((state == S_LEN) && take) begin
      sum <= '0;
    end else if (wr_next) begin
      sum <= sum + rx_data;
    end
  end
`endif

  // Release waits until no write is still in flight, so the micro never sees a half-written image.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      micro_reset <= 1'b1;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      micro_reset <= !((state_next == S_RUN) && !wr_next);
      load_done   <= (state_next == S_RUN) && !wr_next;
      load_err    <= (state_next == S_ERR);
      err_code    <= err_next;
    end
  end

endmodule
